// File: rtl/ocl_axil_frontend.sv
// AXI4-Lite slave front-end for the OCL BAR0 channel: turns single-beat
// AXI-Lite accesses into one-cycle core write strobes and read requests,
// with a read-timeout backstop for a silent core.
module ocl_axil_frontend #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       RD_TIMEOUT   = 256,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic              s_awvalid,
    input  logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awready,
    input  logic              s_wvalid,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_wready,
    output logic              s_bvalid,
    output logic [1:0]        s_bresp,
    input  logic              s_bready,
    input  logic              s_arvalid,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_arready,
    output logic              s_rvalid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    input  logic              s_rready,
    output logic              core_wr_en,
    output logic [ADDR_W-1:0] core_wr_addr,
    output logic [DATA_W-1:0] core_wr_data,
    output logic              core_rd_req,
    output logic [ADDR_W-1:0] core_rd_addr,
    input  logic              core_rd_valid,
    input  logic [DATA_W-1:0] core_rd_data,
    input  logic [1:0]        core_rd_resp
);

    localparam int unsigned CNT_W       = $clog2(RD_TIMEOUT);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ISSUE, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_e;

    w_state_e          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Write path: capture AW and W independently, issue one strobe, respond
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        bvalid_d  = 1'b0;
        unique case (w_state_q)
            W_IDLE, W_WAIT: begin
                if (s_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = s_awaddr;
                end
                if (s_wvalid && wready_q) begin
                    w_held_d  = 1'b1;
                    wr_data_d = s_wdata;
                    wstrb_d   = s_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_ISSUE;
                    // Partial writes are not supported by the core
                    wr_en_d   = (wstrb_d == 4'hF);
                    bresp_d   = (wstrb_d == 4'hF) ? RESP_OKAY : RESP_SLVERR;
                end else if (aw_held_d || w_held_d) begin
                    w_state_d = W_WAIT;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_ISSUE: begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = ((w_state_d == W_IDLE) || (w_state_d == W_WAIT)) && !aw_held_d;
        wready_d  = ((w_state_d == W_IDLE) || (w_state_d == W_WAIT)) && !w_held_d;
    end

    // Read path: request, wait with timeout, respond; yields to core writes
    always_comb begin
        r_state_d = r_state_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        cnt_d     = cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_arvalid && arready_q) begin
                    rd_addr_d = s_araddr;
                    r_state_d = R_REQ;
                end
            end
            R_REQ: begin
                cnt_d = '0;
                if (rd_req_q) begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (core_rd_valid) begin
                    rdata_d   = core_rd_data;
                    rresp_d   = core_rd_resp;
                    r_state_d = R_RESP;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    rdata_d   = TIMEOUT_DATA;
                    rresp_d   = RESP_SLVERR;
                    r_state_d = R_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_RESP: begin
                if (s_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // A pending request is held off for any cycle that carries a core write
        rd_req_d  = (r_state_d == R_REQ) && (r_state_q != R_REQ || !rd_req_q) && !wr_en_d;
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
    end

    // State and registered outputs
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_awready    = awready_q;
    assign s_wready     = wready_q;
    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign core_wr_en   = wr_en_q;
    assign core_wr_addr = wr_addr_q;
    assign core_wr_data = wr_data_q;
    assign s_arready    = arready_q;
    assign s_rvalid     = rvalid_q;
    assign s_rdata      = rdata_q;
    assign s_rresp      = rresp_q;
    assign core_rd_req  = rd_req_q;
    assign core_rd_addr = rd_addr_q;

endmodule

// File: doc/ocl_axil_frontend.md
Name: ocl_axil_frontend

Overview:
- AXI4-Lite slave front-end that terminates the PCIe OCL BAR0 channel after the timing register slice.
- Converts single-beat AXI-Lite accesses into simple one-cycle write strobes and read requests for the Ising machine core.
- Returns core read data to the host, with a read-timeout backstop so a silent core cannot hang the host.
- Sits directly upstream of the Ising core, in the same clock domain.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width on both sides
RD_TIMEOUT, 256, cycles to wait for core_rd_valid before forcing an error response (>=2)
TIMEOUT_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
clk_main_a0  in  1  main clock; all logic on rising edge
rst_main_n  in  1  asynchronous active-low reset
s_awvalid  in  1  AXI-L write address valid
s_awaddr  in  ADDR_W  write address
s_awready  out  1  write address ready
s_wvalid  in  1  write data valid
s_wdata  in  DATA_W  write data
s_wstrb  in  4  write byte strobes
s_wready  out  1  write data ready
s_bvalid  out  1  write response valid
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bready  in  1  write response ready
s_arvalid  in  1  read address valid
s_araddr  in  ADDR_W  read address
s_arready  out  1  read address ready
s_rvalid  out  1  read data valid
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rready  in  1  read data ready
core_wr_en  out  1  one-cycle core write strobe
core_wr_addr  out  ADDR_W  core write address, stable while core_wr_en=1
core_wr_data  out  DATA_W  core write data
core_rd_req  out  1  one-cycle core read request
core_rd_addr  out  ADDR_W  core read address, held until the response is accepted
core_rd_valid  in  1  core read data valid (single-cycle pulse)
core_rd_data  in  DATA_W  core read data
core_rd_resp  in  2  core read response

Behaviour:
- Reset (async assert, sync-to-clock deassert use): all outputs 0, both FSMs idle, timeout counter 0. Reset mid-transaction drops it silently; no response is issued.
- Write FSM states: W_IDLE, W_WAIT, W_ISSUE, W_RESP.
  - AW and W are captured independently. s_awready=1 while no address is held; s_wready=1 while no data is held. Both are 0 in W_ISSUE and W_RESP.
  - W_IDLE/W_WAIT: when address and data are both held (same cycle or any order), go to W_ISSUE.
  - W_ISSUE lasts exactly 1 cycle. If held wstrb==4'hF, core_wr_en=1 and bresp=OKAY. Otherwise core_wr_en stays 0 and bresp=SLVERR (partial writes unsupported). Then go to W_RESP.
  - W_RESP: s_bvalid=1 until s_bready; return to W_IDLE the cycle after the handshake.
  - Minimum latency: AW+W accepted in cycle 0, core_wr_en in cycle 1, bvalid in cycle 2.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_RESP.
  - R_IDLE: s_arready=1. On arvalid, capture araddr into core_rd_addr and go to R_REQ.
  - R_REQ: core_rd_req=1 for one cycle, counter cleared, then go to R_WAIT. If core_wr_en is asserted that same cycle, core_rd_req is deferred; the FSM stays in R_REQ. Writes have priority.
  - R_WAIT: counter increments each cycle.
    - On core_rd_valid, latch core_rd_data and core_rd_resp, then go to R_RESP.
    - If the counter reaches RD_TIMEOUT-1 without core_rd_valid, load TIMEOUT_DATA and SLVERR, then go to R_RESP.
    - core_rd_valid on the timeout cycle itself wins over the timeout.
  - R_RESP: s_rvalid=1 with s_rdata/s_rresp stable until s_rready; return to R_IDLE the cycle after the handshake. s_arready=0 in every state except R_IDLE.
  - core_rd_valid outside R_WAIT (late or spurious) is ignored.
- The read and write paths are otherwise fully independent; outstanding depth is 1 each.

Test Plan:
- Write: AW=0x10 and W=0x0000_00AB with strb F in the same cycle -> core_wr_en for exactly 1 cycle with addr 0x10 and data 0xAB; bvalid 2 cycles after acceptance; bresp=00.
- Write with W arriving 5 cycles before AW, then bready held low 3 cycles -> single core_wr_en after AW; bvalid held 3 cycles; no second AW accepted until the B handshake.
- Partial write with strb=4'h3 -> no core_wr_en; bresp=10.
- Read: AR=0x20, core returns 0x1234 after 7 cycles -> rdata=0x1234, rresp=00, one core_rd_req; read with core silent -> rvalid after RD_TIMEOUT cycles with rdata=0xDEADBEEF and rresp=10; a later core_rd_valid is ignored.
- Read request colliding with core_wr_en -> core_rd_req delayed 1 cycle, never coincident with core_wr_en.
- Assert rst_main_n low while in R_WAIT and W_RESP -> all outputs 0 immediately (asynchronously); a fresh read after release completes normally.
